alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
- Out-of-order reservation station feeding the ALU in the Tomasulo core.
- Accepts renamed instructions from the decoder/issue stage and holds them until both source operands are available.
- Snoops two result broadcast buses (ALU and LSB) to wake up waiting operands.
- Dispatches at most one ready instruction per cycle to the ALU through a registered interface.

Parameters:
RS_SIZE, 16, number of entries; power of two
ROB_IDX_W, 4, ROB index width (ROB depth 16)
OPENUM_W, 6, decoded opcode enum width
OPTYPE_W, 4, opcode class width (BR/JAL/JALR/LUI/AUIPC/ARITH...)

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; low = freeze all state
clr_in  in  1  misprediction flush, synchronous
issue_valid  in  1  decoder presents an instruction this cycle
issue_op  in  OPENUM_W  opcode enum
issue_opType  in  OPTYPE_W  opcode class
issue_Vj / issue_Vk  in  32  operand values, valid when matching Q*_busy=0
issue_Qj_busy / issue_Qk_busy  in  1  operand pending on a ROB entry
issue_Qj / issue_Qk  in  ROB_IDX_W  producing ROB index
issue_rob_index  in  ROB_IDX_W  destination ROB entry
issue_PC  in  32  instruction address
issue_imm  in  32  sign-extended immediate
alu_cdb_valid, alu_cdb_result(32), alu_cdb_rob_index(ROB_IDX_W)  in  ALU result broadcast
lsb_cdb_valid, lsb_cdb_result(32), lsb_cdb_rob_index(ROB_IDX_W)  in  LSB result broadcast
rs_full  out  1  no free entry (combinational from busy bits)
rs_to_alu_ready  out  1  dispatch valid, one-cycle pulse per instruction
rs_to_alu_op / _opType / _rs1 / _rs2 / _rob_index / _PC / _imm  out  as above  dispatched payload, registered

Behaviour:
- Reset or clr_in: all entries not busy; rs_to_alu_ready=0; all payload outputs 0. clr_in has the same priority as rst_in and also discards any issue in the same cycle.
- rdy_in=0: no state or output changes. Outputs hold, including rs_to_alu_ready. The ALU also stalls, so each instruction is consumed exactly once.
- Entry fields: busy, op, opType, Vj, Vk, Qj_busy, Qk_busy, Qj, Qk, rob_index, PC, imm.
- Issue:
  - When issue_valid && !rs_full, write into the lowest-index free entry at the clock edge.
  - issue_valid while rs_full: the request is ignored. The decoder must not do this; the bench flags it.
- Issue-time bypass:
  - If an issued operand has Q*_busy=1 and its Q* equals a valid CDB rob_index in the same cycle, store the CDB value with Q*_busy=0.
  - The ALU CDB is checked before the LSB CDB; a match on both cannot occur.
- Wake-up:
  - Each edge, every busy entry with Qj_busy (Qk_busy) matching a valid CDB index captures that result into Vj (Vk) and clears the busy flag.
  - Both operands may resolve in the same cycle, from the same bus or different buses.
- Select:
  - Combinational, over registered entry state only.
  - Chooses the lowest-index entry with busy && !Qj_busy && !Qk_busy.
  - An operand woken in cycle t makes its entry eligible at cycle t+1.
- Dispatch:
  - If an entry is selected, at the edge: rs_to_alu_ready<=1, payload<=entry (rs1=Vj, rs2=Vk), entry busy<=0.
  - Otherwise rs_to_alu_ready<=0; payload holds its last value.
  - Latency: instruction issued with both operands ready at edge e is dispatched at edge e+1, and seen by the ALU at edge e+2.
- Simultaneous issue and dispatch: both occur. The entry freed by dispatch is not counted free until the next cycle, so rs_full reflects pre-edge busy bits.
- rs_full = all RS_SIZE busy bits set.
- An entry never both dispatches and captures CDB data in the same cycle, because dispatch requires no pending operands.

Test Plan:
- Reset, then issue ADD with Vj=5, Vk=7, both ready, rob 3 -> one cycle later rs_to_alu_ready=1, rs1=5, rs2=7, rob_index=3; the following cycle rs_to_alu_ready=0.
- Issue SUB with Qj_busy=1, Qj=2; two cycles later alu_cdb_valid=1, index 2, result 0x10 -> dispatch one cycle after the CDB with rs1=0x10.
- Issue with Qk=4 in the same cycle lsb_cdb broadcasts index 4, value 0xABCD -> entry stored ready; dispatched next cycle with rs2=0xABCD.
- Fill 16 entries all waiting on rob 9 -> rs_full=1 and a 17th issue is ignored. Broadcast rob 9 -> all 16 dispatch on consecutive cycles, lowest index first; rs_full drops after the first dispatch edge.
- Three pending entries, then clr_in pulsed -> next cycle rs_to_alu_ready=0, rs_full=0, no later dispatch even if the CDB broadcasts the awaited index.
- Dispatch pending with rdy_in held low for 3 cycles -> outputs frozen; after rdy_in returns, exactly one dispatch occurs per entry and no entry is lost or duplicated.

Source files
------------

// File: rtl/alu_reservation_station_if.sv
// Issue, result-broadcast and dispatch signals of the ALU reservation station.
// Handshake: an issue is taken at a clock edge when issue_valid=1, rs_full=0 and
// rdy_in=1; a dispatch is offered for one cycle by rs_to_alu_ready=1 and is always
// accepted (there is no back-pressure from the ALU, it freezes with rdy_in instead).
interface alu_reservation_station_if #(
    parameter int ROB_IDX_W = 4,
    parameter int OPENUM_W  = 6,
    parameter int OPTYPE_W  = 4
);
    logic                 issue_valid;
    logic [OPENUM_W-1:0]  issue_op;
    logic [OPTYPE_W-1:0]  issue_opType;
    logic [31:0]          issue_Vj;
    logic [31:0]          issue_Vk;
    logic                 issue_Qj_busy;
    logic                 issue_Qk_busy;
    logic [ROB_IDX_W-1:0] issue_Qj;
    logic [ROB_IDX_W-1:0] issue_Qk;
    logic [ROB_IDX_W-1:0] issue_rob_index;
    logic [31:0]          issue_PC;
    logic [31:0]          issue_imm;

    logic                 alu_cdb_valid;
    logic [31:0]          alu_cdb_result;
    logic [ROB_IDX_W-1:0] alu_cdb_rob_index;
    logic                 lsb_cdb_valid;
    logic [31:0]          lsb_cdb_result;
    logic [ROB_IDX_W-1:0] lsb_cdb_rob_index;

    logic                 rs_full;
    logic                 rs_to_alu_ready;
    logic [OPENUM_W-1:0]  rs_to_alu_op;
    logic [OPTYPE_W-1:0]  rs_to_alu_opType;
    logic [31:0]          rs_to_alu_rs1;
    logic [31:0]          rs_to_alu_rs2;
    logic [ROB_IDX_W-1:0] rs_to_alu_rob_index;
    logic [31:0]          rs_to_alu_PC;
    logic [31:0]          rs_to_alu_imm;

    // Decoder / CDB / ALU side.
    modport master (
        output issue_valid, issue_op, issue_opType, issue_Vj, issue_Vk,
               issue_Qj_busy, issue_Qk_busy, issue_Qj, issue_Qk,
               issue_rob_index, issue_PC, issue_imm,
               alu_cdb_valid, alu_cdb_result, alu_cdb_rob_index,
               lsb_cdb_valid, lsb_cdb_result, lsb_cdb_rob_index,
        input  rs_full, rs_to_alu_ready, rs_to_alu_op, rs_to_alu_opType,
               rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_rob_index,
               rs_to_alu_PC, rs_to_alu_imm
    );

    // Reservation station side.
    modport slave (
        input  issue_valid, issue_op, issue_opType, issue_Vj, issue_Vk,
               issue_Qj_busy, issue_Qk_busy, issue_Qj, issue_Qk,
               issue_rob_index, issue_PC, issue_imm,
               alu_cdb_valid, alu_cdb_result, alu_cdb_rob_index,
               lsb_cdb_valid, lsb_cdb_result, lsb_cdb_rob_index,
        output rs_full, rs_to_alu_ready, rs_to_alu_op, rs_to_alu_opType,
               rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_rob_index,
               rs_to_alu_PC, rs_to_alu_imm
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds renamed instructions until both operands are
// known, snoops the ALU and LSB result buses, and dispatches the lowest-index
// ready entry each cycle through registered outputs.
module alu_reservation_station #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_IDX_W = 4,
    parameter int OPENUM_W  = 6,
    parameter int OPTYPE_W  = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic clr_in,
    alu_reservation_station_if.slave rs_bus
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]   r_busy;
    logic [RS_SIZE-1:0]   r_qj_busy;
    logic [RS_SIZE-1:0]   r_qk_busy;
    logic [OPENUM_W-1:0]  r_op     [RS_SIZE];
    logic [OPTYPE_W-1:0]  r_optype [RS_SIZE];
    logic [31:0]          r_vj     [RS_SIZE];
    logic [31:0]          r_vk     [RS_SIZE];
    logic [ROB_IDX_W-1:0] r_qj     [RS_SIZE];
    logic [ROB_IDX_W-1:0] r_qk     [RS_SIZE];
    logic [ROB_IDX_W-1:0] r_rob    [RS_SIZE];
    logic [31:0]          r_pc     [RS_SIZE];
    logic [31:0]          r_imm    [RS_SIZE];

    logic                 r_out_ready;
    logic [OPENUM_W-1:0]  r_out_op;
    logic [OPTYPE_W-1:0]  r_out_optype;
    logic [31:0]          r_out_rs1;
    logic [31:0]          r_out_rs2;
    logic [ROB_IDX_W-1:0] r_out_rob;
    logic [31:0]          r_out_pc;
    logic [31:0]          r_out_imm;

    logic                 w_full;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_sel_valid;
    logic [IDX_W-1:0]     w_sel_idx;
    logic [31:0]          w_iss_vj;
    logic [31:0]          w_iss_vk;
    logic                 w_iss_qj_busy;
    logic                 w_iss_qk_busy;

    // Full only when every entry is occupied before the edge; a same-cycle
    // dispatch does not free a slot for a same-cycle issue.
    assign w_full = &r_busy;

    assign rs_bus.rs_full             = w_full;
    assign rs_bus.rs_to_alu_ready     = r_out_ready;
    assign rs_bus.rs_to_alu_op        = r_out_op;
    assign rs_bus.rs_to_alu_opType    = r_out_optype;
    assign rs_bus.rs_to_alu_rs1       = r_out_rs1;
    assign rs_bus.rs_to_alu_rs2       = r_out_rs2;
    assign rs_bus.rs_to_alu_rob_index = r_out_rob;
    assign rs_bus.rs_to_alu_PC        = r_out_pc;
    assign rs_bus.rs_to_alu_imm       = r_out_imm;

    // Lowest-index free entry (descending scan so the lowest match wins).
    always_comb begin
        w_free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_free_idx = IDX_W'(i);
        end
    end

    // Lowest-index entry with both operands present, from registered state only.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (r_busy[i] && !r_qj_busy[i] && !r_qk_busy[i]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end

    // Issue-time bypass: a pending operand produced on a CDB this very cycle is
    // captured directly; the ALU bus is looked at first.
    always_comb begin
        w_iss_vj      = rs_bus.issue_Vj;
        w_iss_qj_busy = rs_bus.issue_Qj_busy;
        w_iss_vk      = rs_bus.issue_Vk;
        w_iss_qk_busy = rs_bus.issue_Qk_busy;
        if (rs_bus.issue_Qj_busy) begin
            if (rs_bus.alu_cdb_valid && rs_bus.alu_cdb_rob_index == rs_bus.issue_Qj) begin
                w_iss_vj      = rs_bus.alu_cdb_result;
                w_iss_qj_busy = 1'b0;
            end else if (rs_bus.lsb_cdb_valid && rs_bus.lsb_cdb_rob_index == rs_bus.issue_Qj) begin
                w_iss_vj      = rs_bus.lsb_cdb_result;
                w_iss_qj_busy = 1'b0;
            end
        end
        if (rs_bus.issue_Qk_busy) begin
            if (rs_bus.alu_cdb_valid && rs_bus.alu_cdb_rob_index == rs_bus.issue_Qk) begin
                w_iss_vk      = rs_bus.alu_cdb_result;
                w_iss_qk_busy = 1'b0;
            end else if (rs_bus.lsb_cdb_valid && rs_bus.lsb_cdb_rob_index == rs_bus.issue_Qk) begin
                w_iss_vk      = rs_bus.lsb_cdb_result;
                w_iss_qk_busy = 1'b0;
            end
        end
    end

    // Entry state and dispatch registers: flush, wake-up, dispatch, issue.
    always_ff @(posedge clk_in) begin
        if (rst_in || clr_in) begin
            r_busy       <= '0;
            r_out_ready  <= 1'b0;
            r_out_op     <= '0;
            r_out_optype <= '0;
            r_out_rs1    <= '0;
            r_out_rs2    <= '0;
            r_out_rob    <= '0;
            r_out_pc     <= '0;
            r_out_imm    <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && r_qj_busy[i]) begin
                    if (rs_bus.alu_cdb_valid && r_qj[i] == rs_bus.alu_cdb_rob_index) begin
                        r_vj[i]      <= rs_bus.alu_cdb_result;
                        r_qj_busy[i] <= 1'b0;
                    end else if (rs_bus.lsb_cdb_valid && r_qj[i] == rs_bus.lsb_cdb_rob_index) begin
                        r_vj[i]      <= rs_bus.lsb_cdb_result;
                        r_qj_busy[i] <= 1'b0;
                    end
                end
                if (r_busy[i] && r_qk_busy[i]) begin
                    if (rs_bus.alu_cdb_valid && r_qk[i] == rs_bus.alu_cdb_rob_index) begin
                        r_vk[i]      <= rs_bus.alu_cdb_result;
                        r_qk_busy[i] <= 1'b0;
                    end else if (rs_bus.lsb_cdb_valid && r_qk[i] == rs_bus.lsb_cdb_rob_index) begin
                        r_vk[i]      <= rs_bus.lsb_cdb_result;
                        r_qk_busy[i] <= 1'b0;
                    end
                end
            end

            if (w_sel_valid) begin
                r_out_ready         <= 1'b1;
                r_out_op            <= r_op[w_sel_idx];
                r_out_optype        <= r_optype[w_sel_idx];
                r_out_rs1           <= r_vj[w_sel_idx];
                r_out_rs2           <= r_vk[w_sel_idx];
                r_out_rob           <= r_rob[w_sel_idx];
                r_out_pc            <= r_pc[w_sel_idx];
                r_out_imm           <= r_imm[w_sel_idx];
                r_busy[w_sel_idx]   <= 1'b0;
            end else begin
                r_out_ready <= 1'b0;
            end

            // The free slot is never the selected slot (selection needs busy=1).
            if (rs_bus.issue_valid && !w_full) begin
                r_busy[w_free_idx]    <= 1'b1;
                r_op[w_free_idx]      <= rs_bus.issue_op;
                r_optype[w_free_idx]  <= rs_bus.issue_opType;
                r_vj[w_free_idx]      <= w_iss_vj;
                r_vk[w_free_idx]      <= w_iss_vk;
                r_qj_busy[w_free_idx] <= w_iss_qj_busy;
                r_qk_busy[w_free_idx] <= w_iss_qk_busy;
                r_qj[w_free_idx]      <= rs_bus.issue_Qj;
                r_qk[w_free_idx]      <= rs_bus.issue_Qk;
                r_rob[w_free_idx]     <= rs_bus.issue_rob_index;
                r_pc[w_free_idx]      <= rs_bus.issue_PC;
                r_imm[w_free_idx]     <= rs_bus.issue_imm;
            end
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios followed by random
// traffic, all checked against a slot-array reference model of the station.
module tb_alu_reservation_station;
    logic clk = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    logic clr_in = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_disp   = 0;

    always #5 clk = ~clk;

    alu_reservation_station_if #(.ROB_IDX_W(4), .OPENUM_W(6), .OPTYPE_W(4)) bus ();

    alu_reservation_station #(.RS_SIZE(16), .ROB_IDX_W(4), .OPENUM_W(6), .OPTYPE_W(4)) dut (
        .clk_in (clk),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clr_in (clr_in),
        .rs_bus (bus)
    );

    typedef struct packed {
        logic        busy;
        logic [5:0]  op;
        logic [3:0]  ot;
        logic [31:0] vj;
        logic [31:0] vk;
        logic        qjb;
        logic        qkb;
        logic [3:0]  qj;
        logic [3:0]  qk;
        logic [3:0]  rob;
        logic [31:0] pc;
        logic [31:0] imm;
    } slot_t;

    slot_t       m_rs [16];
    logic        e_ready = 1'b0;
    logic [5:0]  e_op = '0;
    logic [3:0]  e_ot = '0;
    logic [31:0] e_rs1 = '0, e_rs2 = '0, e_pc = '0, e_imm = '0;
    logic [3:0]  e_rob = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_full();
        bit f = 1'b1;
        for (int i = 0; i < 16; i++) if (!m_rs[i].busy) f = 1'b0;
        return f;
    endfunction

    // Result of looking for a pending operand on the two broadcast buses: {still_pending, value}.
    function automatic logic [32:0] snoop(logic qb, logic [3:0] q, logic [31:0] v);
        if (qb && bus.alu_cdb_valid && bus.alu_cdb_rob_index == q) return {1'b0, bus.alu_cdb_result};
        if (qb && bus.lsb_cdb_valid && bus.lsb_cdb_rob_index == q) return {1'b0, bus.lsb_cdb_result};
        return {qb, v};
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        slot_t nxt [16];
        int    sel = -1;
        int    free = -1;
        if (rst_in || clr_in) begin
            for (int i = 0; i < 16; i++) m_rs[i].busy = 1'b0;
            e_ready = 0; e_op = 0; e_ot = 0; e_rs1 = 0; e_rs2 = 0; e_rob = 0; e_pc = 0; e_imm = 0;
        end else if (rdy_in) begin
            nxt = m_rs;
            for (int i = 0; i < 16; i++) begin
                if (!m_rs[i].busy && free < 0) free = i;
                if (m_rs[i].busy && !m_rs[i].qjb && !m_rs[i].qkb && sel < 0) sel = i;
            end
            for (int i = 0; i < 16; i++) begin
                if (m_rs[i].busy) begin
                    {nxt[i].qjb, nxt[i].vj} = snoop(m_rs[i].qjb, m_rs[i].qj, m_rs[i].vj);
                    {nxt[i].qkb, nxt[i].vk} = snoop(m_rs[i].qkb, m_rs[i].qk, m_rs[i].vk);
                end
            end
            if (sel >= 0) begin
                e_ready = 1; e_op = m_rs[sel].op; e_ot = m_rs[sel].ot;
                e_rs1 = m_rs[sel].vj; e_rs2 = m_rs[sel].vk; e_rob = m_rs[sel].rob;
                e_pc = m_rs[sel].pc; e_imm = m_rs[sel].imm;
                nxt[sel].busy = 1'b0;
            end else begin
                e_ready = 0;
            end
            if (bus.issue_valid && free >= 0) begin
                nxt[free].busy = 1'b1;
                nxt[free].op   = bus.issue_op;
                nxt[free].ot   = bus.issue_opType;
                nxt[free].qj   = bus.issue_Qj;
                nxt[free].qk   = bus.issue_Qk;
                nxt[free].rob  = bus.issue_rob_index;
                nxt[free].pc   = bus.issue_PC;
                nxt[free].imm  = bus.issue_imm;
                {nxt[free].qjb, nxt[free].vj} = snoop(bus.issue_Qj_busy, bus.issue_Qj, bus.issue_Vj);
                {nxt[free].qkb, nxt[free].vk} = snoop(bus.issue_Qk_busy, bus.issue_Qk, bus.issue_Vk);
            end
            m_rs = nxt;
        end
    endtask

    task automatic idle_inputs();
        bus.issue_valid = 0; bus.alu_cdb_valid = 0; bus.lsb_cdb_valid = 0;
        clr_in = 0; rst_in = 0;
    endtask

    // One clock: update model, take the edge, compare all outputs, drop one-shot inputs.
    task automatic step();
        logic rdy_at_edge;
        rdy_at_edge = rdy_in;
        model_step();
        @(posedge clk);
        #1;
        check("ready", 32'(bus.rs_to_alu_ready), 32'(e_ready));
        check("full",  32'(bus.rs_full), 32'(model_full()));
        check("op",    32'(bus.rs_to_alu_op), 32'(e_op));
        check("optype", 32'(bus.rs_to_alu_opType), 32'(e_ot));
        check("rs1",   bus.rs_to_alu_rs1, e_rs1);
        check("rs2",   bus.rs_to_alu_rs2, e_rs2);
        check("rob",   32'(bus.rs_to_alu_rob_index), 32'(e_rob));
        check("pc",    bus.rs_to_alu_PC, e_pc);
        check("imm",   bus.rs_to_alu_imm, e_imm);
        if (rdy_at_edge && !rst_in && !clr_in && bus.rs_to_alu_ready) n_disp++;
        idle_inputs();
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic qjb, input logic [3:0] qj, input logic qkb, input logic [3:0] qk,
                         input logic [3:0] rob, input logic [31:0] pc);
        bus.issue_valid = 1; bus.issue_op = op; bus.issue_opType = 4'd5;
        bus.issue_Vj = vj; bus.issue_Vk = vk;
        bus.issue_Qj_busy = qjb; bus.issue_Qj = qj;
        bus.issue_Qk_busy = qkb; bus.issue_Qk = qk;
        bus.issue_rob_index = rob; bus.issue_PC = pc; bus.issue_imm = pc ^ 32'h5a5a;
    endtask

    task automatic alu_cdb(input logic [3:0] idx, input logic [31:0] val);
        bus.alu_cdb_valid = 1; bus.alu_cdb_rob_index = idx; bus.alu_cdb_result = val;
    endtask

    task automatic lsb_cdb(input logic [3:0] idx, input logic [31:0] val);
        bus.lsb_cdb_valid = 1; bus.lsb_cdb_rob_index = idx; bus.lsb_cdb_result = val;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_rs[i] = '0;
        bus.issue_op = 0; bus.issue_opType = 0; bus.issue_Vj = 0; bus.issue_Vk = 0;
        bus.issue_Qj_busy = 0; bus.issue_Qk_busy = 0; bus.issue_Qj = 0; bus.issue_Qk = 0;
        bus.issue_rob_index = 0; bus.issue_PC = 0; bus.issue_imm = 0;
        bus.alu_cdb_result = 0; bus.alu_cdb_rob_index = 0;
        bus.lsb_cdb_result = 0; bus.lsb_cdb_rob_index = 0;
        bus.issue_valid = 0; bus.alu_cdb_valid = 0; bus.lsb_cdb_valid = 0;

        // Reset.
        rst_in = 1; step();
        rst_in = 1; step();
        check("rst_ready", 32'(bus.rs_to_alu_ready), 0);
        check("rst_full", 32'(bus.rs_full), 0);

        // ADD with both operands ready.
        issue(6'd1, 32'd5, 32'd7, 0, 0, 0, 0, 4'd3, 32'h100); step();
        check("add_not_yet", 32'(bus.rs_to_alu_ready), 0);
        step();
        check("add_ready", 32'(bus.rs_to_alu_ready), 1);
        check("add_rs1", bus.rs_to_alu_rs1, 5);
        check("add_rs2", bus.rs_to_alu_rs2, 7);
        check("add_rob", 32'(bus.rs_to_alu_rob_index), 3);
        step();
        check("add_pulse", 32'(bus.rs_to_alu_ready), 0);

        // SUB waiting on rob 2, woken by the ALU CDB.
        issue(6'd2, 32'd0, 32'd1, 1, 4'd2, 0, 0, 4'd5, 32'h104); step();
        step(); step();
        alu_cdb(4'd2, 32'h10); step();
        check("sub_wait", 32'(bus.rs_to_alu_ready), 0);
        step();
        check("sub_ready", 32'(bus.rs_to_alu_ready), 1);
        check("sub_rs1", bus.rs_to_alu_rs1, 32'h10);

        // Issue-time bypass from the LSB CDB.
        issue(6'd3, 32'd9, 32'd0, 0, 0, 1, 4'd4, 4'd6, 32'h108);
        lsb_cdb(4'd4, 32'hABCD); step();
        step();
        check("byp_ready", 32'(bus.rs_to_alu_ready), 1);
        check("byp_rs2", bus.rs_to_alu_rs2, 32'hABCD);
        step();

        // Fill all 16 entries waiting on rob 9, then an ignored 17th issue.
        for (int i = 0; i < 16; i++) begin
            issue(6'd4, 32'd0, 32'(i), 1, 4'd9, 0, 0, 4'(i), 32'h200 + 32'(4 * i)); step();
        end
        check("fill_full", 32'(bus.rs_full), 1);
        issue(6'd5, 32'd1, 32'd1, 0, 0, 0, 0, 4'd15, 32'hDEAD); step();
        alu_cdb(4'd9, 32'h99); step();
        check("wake_full", 32'(bus.rs_full), 1);
        for (int i = 0; i < 16; i++) begin
            step();
            check("drain_ready", 32'(bus.rs_to_alu_ready), 1);
            check("drain_pc", bus.rs_to_alu_PC, 32'h200 + 32'(4 * i));
            if (i == 0) check("drain_full", 32'(bus.rs_full), 0);
        end
        step();
        check("drain_done", 32'(bus.rs_to_alu_ready), 0);

        // Flush with three pending entries; a later broadcast must not revive them.
        for (int i = 0; i < 3; i++) begin
            issue(6'd6, 32'd0, 32'd0, 1, 4'd12, 0, 0, 4'(i), 32'h300 + 32'(i)); step();
        end
        clr_in = 1; issue(6'd7, 32'd1, 32'd1, 0, 0, 0, 0, 4'd1, 32'h3FF); step();
        check("clr_ready", 32'(bus.rs_to_alu_ready), 0);
        check("clr_full", 32'(bus.rs_full), 0);
        alu_cdb(4'd12, 32'h77); step();
        step(); step();
        check("clr_no_disp", 32'(bus.rs_to_alu_ready), 0);

        // Freeze with dispatches pending.
        n_disp = 0;
        for (int i = 0; i < 3; i++) begin
            issue(6'd8, 32'(i), 32'(i + 1), 0, 0, 0, 0, 4'(i), 32'h400 + 32'(i)); step();
        end
        rdy_in = 0;
        for (int i = 0; i < 3; i++) begin
            alu_cdb(4'd1, 32'h1234); step();
        end
        rdy_in = 1;
        for (int i = 0; i < 5; i++) step();
        check("freeze_count", 32'(n_disp), 3);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            if (rdy_in && $urandom_range(0, 149) == 0) clr_in = 1;
            if ($urandom_range(0, 1) == 1 && !model_full())
                issue(6'($urandom), $urandom, $urandom, 1'($urandom), 4'($urandom),
                      1'($urandom), 4'($urandom), 4'($urandom), $urandom);
            if ($urandom_range(0, 9) < 3) alu_cdb(4'($urandom), $urandom);
            if ($urandom_range(0, 9) < 3) begin
                lsb_cdb(4'($urandom), $urandom);
                if (bus.alu_cdb_valid && bus.lsb_cdb_rob_index == bus.alu_cdb_rob_index)
                    bus.lsb_cdb_rob_index = bus.lsb_cdb_rob_index ^ 4'd1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
